// File: rtl/lpddr_port_arbiter.sv
// lpddr_port_arbiter: shares one LPDDR3 command port between ADC, RGMII and ULPI requesters,
// round-robin with ADC-urgent and starvation overrides, grant held for one burst, watchdog abort.
module lpddr_port_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int STARVE_LIM = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_100mhz_buf,
    input  logic                  RESET_N,
    input  logic [2:0]            req_valid,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [11:0]           req_len,
    output logic [2:0]            req_ready,
    input  logic                  adc_urgent,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_W-1:0]     mem_cmd_addr,
    output logic [3:0]            mem_cmd_len,
    output logic [1:0]            mem_cmd_id,
    input  logic                  mem_done,
    output logic [2:0]            grant,
    output logic                  err_timeout,
    output logic                  starve_hit
);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t        state;
    logic [1:0]    rr_ptr, win, rr_win, starve_win;
    logic [2:0]    starved;
    logic          urgent;
    logic [CW-1:0] wait_cnt [3];
    logic [TW-1:0] wd_cnt;

    always_comb begin
        urgent = adc_urgent && req_valid[0];
        for (int i = 0; i < 3; i++) starved[i] = req_valid[i] && wait_cnt[i] == CW'(STARVE_LIM);
        starve_win = starved[0] ? 2'd0 : starved[1] ? 2'd1 : 2'd2;
        rr_win = rr_ptr == 2'd0 ? (req_valid[0] ? 2'd0 : req_valid[1] ? 2'd1 : 2'd2) :
                 rr_ptr == 2'd1 ? (req_valid[1] ? 2'd1 : req_valid[2] ? 2'd2 : 2'd0) :
                                  (req_valid[2] ? 2'd2 : req_valid[0] ? 2'd0 : 2'd1);
        win = urgent ? 2'd0 : |starved ? starve_win : rr_win;
    end

    assign req_ready = mem_cmd_valid && mem_cmd_ready ? grant : 3'b000;

    // a port only ages while it is asking and not owning the data path
    always_ff @(posedge clk_100mhz_buf or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (!req_valid[i] || grant[i] || (state == IDLE && win == 2'(i)))
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != CW'(STARVE_LIM))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz_buf or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            rr_ptr        <= 2'd0;
            wd_cnt        <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_len   <= 4'd0;
            mem_cmd_id    <= 2'd0;
            grant         <= 3'b000;
            err_timeout   <= 1'b0;
            starve_hit    <= 1'b0;
        end else begin
            starve_hit <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    state         <= ISSUE;
                    mem_cmd_valid <= 1'b1;
                    mem_cmd_we    <= req_we[win];
                    mem_cmd_addr  <= req_addr[win*ADDR_W +: ADDR_W];
                    mem_cmd_len   <= req_len[win*4 +: 4];
                    mem_cmd_id    <= win;
                    grant         <= 3'b001 << win;
                    rr_ptr        <= win == 2'd2 ? 2'd0 : win + 2'd1;
                    starve_hit    <= !urgent && |starved;
                end
                ISSUE: if (mem_cmd_ready) begin
                    state         <= WAIT_DONE;
                    mem_cmd_valid <= 1'b0;
                    wd_cnt        <= '0;
                end
                WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (mem_done) begin
                        state <= IDLE;
                        grant <= 3'b000;
                    end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        grant       <= 3'b000;
                        err_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lpddr_port_arbiter.sv
// tb_lpddr_port_arbiter: directed checks of arbitration order, overrides, backpressure, watchdog and reset.
module tb_lpddr_port_arbiter;
    localparam int AW = 27;
    logic          clk_100mhz_buf = 1'b0;
    logic          RESET_N = 1'b0;
    logic [2:0]    req_valid = 3'b000;
    logic [2:0]    req_we = 3'b101;
    logic [3*AW-1:0] req_addr = {27'h7FFFFFF, 27'h0000100, 27'h0ABCDEF};
    logic [11:0]   req_len = 12'hF70;
    logic [2:0]    req_ready;
    logic          adc_urgent = 1'b0;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b1;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [3:0]    mem_cmd_len;
    logic [1:0]    mem_cmd_id;
    logic          mem_done = 1'b0;
    logic [2:0]    grant;
    logic          err_timeout;
    logic          starve_hit;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr [3] = '{27'h0ABCDEF, 27'h0000100, 27'h7FFFFFF};
    logic [3:0]    exp_len  [3] = '{4'd0, 4'd7, 4'd15};
    logic [2:0]    exp_we = 3'b101;
    int            rr_order [8] = '{2, 0, 1, 2, 0, 1, 2, 0};

    lpddr_port_arbiter #(.ADDR_W(AW), .STARVE_LIM(8), .TIMEOUT(32)) dut (
        .clk_100mhz_buf(clk_100mhz_buf), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .adc_urgent(adc_urgent),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len), .mem_cmd_id(mem_cmd_id),
        .mem_done(mem_done), .grant(grant), .err_timeout(err_timeout), .starve_hit(starve_hit)
    );

    always #5 clk_100mhz_buf = ~clk_100mhz_buf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100mhz_buf);
    endtask

    // one full burst: arbitrate, accept immediately, mem_done after d idle cycles
    task automatic serve(input int id, input logic st, input int d);
        tick();
        chk("grant", 32'(grant), 32'(3'b001 << id));
        chk("cmd_valid", 32'(mem_cmd_valid), 1);
        chk("cmd_id", 32'(mem_cmd_id), id);
        chk("cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr[id]));
        chk("cmd_len", 32'(mem_cmd_len), 32'(exp_len[id]));
        chk("cmd_we", 32'(mem_cmd_we), 32'(exp_we[id]));
        chk("req_ready", 32'(req_ready), 32'(3'b001 << id));
        chk("starve_hit", 32'(starve_hit), 32'(st));
        tick();
        chk("cmd_valid_drop", 32'(mem_cmd_valid), 0);
        chk("req_ready_quiet", 32'(req_ready), 0);
        chk("starve_pulse_end", 32'(starve_hit), 0);
        chk("grant_hold", 32'(grant), 32'(3'b001 << id));
        repeat (d) tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("grant_release", 32'(grant), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cmd_valid", 32'(mem_cmd_valid), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_starve", 32'(starve_hit), 0);
        RESET_N = 1'b1;
        tick();

        req_valid = 3'b010;
        serve(1, 1'b0, 0);
        req_valid = 3'b000;

        req_valid = 3'b111;
        for (int k = 0; k < 8; k++) serve(rr_order[k], 1'b0, 0);
        req_valid = 3'b000;
        tick();
        chk("idle_grant", 32'(grant), 0);

        req_valid = 3'b111;
        adc_urgent = 1'b1;
        serve(0, 1'b0, 0);
        adc_urgent = 1'b0;
        serve(1, 1'b0, 0);
        req_valid = 3'b000;
        tick();

        req_valid = 3'b101;
        adc_urgent = 1'b1;
        serve(0, 1'b0, 8);
        serve(0, 1'b0, 0);
        adc_urgent = 1'b0;
        serve(2, 1'b1, 0);
        serve(0, 1'b0, 0);
        req_valid = 3'b000;
        tick();

        req_valid = 3'b001;
        mem_cmd_ready = 1'b0;
        tick();
        chk("bp_grant", 32'(grant), 1);
        req_valid = 3'b000;
        req_addr[AW-1:0] = 27'h1234567;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", 32'(mem_cmd_valid), 1);
            chk("bp_addr", 32'(mem_cmd_addr), 32'h0ABCDEF);
            chk("bp_ready", 32'(req_ready), 0);
        end
        req_addr[AW-1:0] = 27'h0ABCDEF;
        mem_cmd_ready = 1'b1;
        #1;
        chk("bp_accept", 32'(req_ready), 1);
        tick();
        chk("wd_valid_drop", 32'(mem_cmd_valid), 0);
        repeat (31) tick();
        chk("wd_grant_hold", 32'(grant), 1);
        chk("wd_err_early", 32'(err_timeout), 0);
        tick();
        chk("wd_grant_clear", 32'(grant), 0);
        chk("wd_err_set", 32'(err_timeout), 1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick();
        chk("stray_done_grant", 32'(grant), 0);
        chk("stray_done_valid", 32'(mem_cmd_valid), 0);
        chk("err_sticky", 32'(err_timeout), 1);

        req_valid = 3'b010;
        tick();
        tick();
        chk("mid_burst_grant", 32'(grant), 2);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_valid", 32'(mem_cmd_valid), 0);
        chk("mid_rst_err", 32'(err_timeout), 0);
        chk("mid_rst_id", 32'(mem_cmd_id), 0);
        req_valid = 3'b111;
        tick();
        RESET_N = 1'b1;
        serve(0, 1'b0, 0);
        serve(1, 1'b0, 0);
        serve(2, 1'b0, 0);
        req_valid = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
